uio_bus_arbiter: RTL
====================

# uio_bus_arbiter

Round-robin arbiter and sequencer that shares the 8-bit bidirectional `uio` pin bank between up to `NREQ` internal requesters inside the top-level user module. Each grant runs one burst transaction: an optional bus-turnaround phase, then 1..`MAX_BEATS` write or read beats. The block owns `uio_out`/`uio_oe` so no two requesters ever drive the pins together, and it never switches direction without an all-inputs gap.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `MAX_BEATS`, 8: maximum beats per burst, power of 2, ≥2; `LW = $clog2(MAX_BEATS)`.
- `TURNAROUND`, 1: cycles with `uio_oe=0` before every burst, 0..3.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ena`  in  1  high enables new grants; has no effect on an active burst.
- `req`  in  NREQ  request level per requester; held until that requester's `done`.
- `req_wr`  in  NREQ  1=write (drive pins), 0=read; sampled at grant.
- `req_len`  in  NREQ*LW  beats-1 per requester; sampled at grant.
- `wdata`  in  NREQ*8  write byte per requester, read by the arbiter in every write beat.
- `uio_in`  in  8  pin input path.
- `gnt`  out  NREQ  one-hot owner, high during TURN and XFER.
- `beat`  out  1  high in each XFER cycle.
- `done`  out  NREQ  one-cycle pulse to the owner after its last beat.
- `rdata`  out  8  registered `uio_in` from the previous read beat.
- `rvalid`  out  1  high for one cycle with each `rdata` update.
- `uio_out`  out  8  pin output path.
- `uio_oe`  out  8  pin enables (1=output).

## Operation
- FSM states: IDLE, TURN, XFER.
- IDLE: if `ena` and `|req`, select the owner by round-robin. Search order starts at `(last_owner+1) mod NREQ`.
  - Latch owner, `req_wr[owner]` and `req_len[owner]` into `beat_cnt`.
  - Next state is TURN, or XFER directly if `TURNAROUND=0`.
- TURN: counts down `TURNAROUND` cycles, then goes to XFER.
  - `uio_oe=0x00`, `uio_out=0x00`.
- XFER: one beat per cycle. Decrement `beat_cnt`. When it is 0, go to IDLE and update `last_owner`.
  - Write burst: `uio_oe=0xFF`, `uio_out=wdata[owner]`. These are combinational from the state registers and the owner's `wdata`.
  - Read burst: `uio_oe=0x00`, `uio_out=0x00`. `uio_in` is registered into `rdata` and `rvalid` is set for the next cycle.
- Outside XFER-write, `uio_oe=0x00` and `uio_out=0x00` at all times.
- `done[owner]` pulses in the first IDLE cycle after the burst. At least one IDLE cycle separates consecutive bursts, so a new grant can be issued no earlier than that cycle's edge.
- Dropping `req[owner]` mid-burst is ignored; the burst completes. Changes to `req_wr`/`req_len` after the grant are ignored.
- Requesters whose `req` is low are skipped in the search. A lone requester is granted repeatedly.
- Reset: state=IDLE, `last_owner=NREQ-1` (requester 0 has first priority), `beat_cnt=0`.
  - All outputs are 0: `gnt`, `beat`, `done`, `rdata`, `rvalid`, `uio_out`, `uio_oe`.
  - Reset asserted mid-burst aborts it at that edge: no `done`, no further beats.

## Timing
- `req` high in IDLE at edge k: `gnt` is high from k+1.
- First beat is in cycle k+1+`TURNAROUND`. The burst occupies `TURNAROUND + len + 1` cycles.
- `done` is in the cycle after the last beat. `gnt` is low in that cycle.
- Read beat in cycle n: `rdata`/`rvalid` are valid in cycle n+1, including after the last beat, coincident with `done`.
- Back-to-back bursts from different owners: pins are never driven in the IDLE cycle or the TURN cycles, which guarantees ≥`1+TURNAROUND` cycles of `uio_oe=0` between writers.

## Test plan
- **Reset:** hold `rst` 2 cycles with random inputs. All outputs must be 0. Then `req=0001`: `gnt=0001` must appear one cycle later.
- **Write burst:** `req[1]`, `req_wr=1`, `req_len=2`, `wdata[1]=0xA5`.
  - `gnt=0010` for 4 cycles (1 TURN + 3 beats).
  - `uio_oe=0xFF` and `uio_out=0xA5` for exactly 3 cycles; `beat` high 3 cycles.
  - `done=0010` one cycle after the last beat.
- **Read burst:** `req[2]`, `req_wr=0`, `req_len=1`, `uio_in=0x3C` then `0xC3`.
  - `uio_oe=0x00` throughout.
  - `rvalid` pulses twice with `rdata` 0x3C then 0xC3.
- **Fairness:** `req=1111`, all `req_len=0`, held. Grant order must be 0,1,2,3,0, each burst 2 cycles plus 1 IDLE. Repeat with `req=1010`: order 1,3,1.
- **Enable:** `ena=0` with `req=0100` gives no `gnt` for 10 cycles. Raising `ena` gives a grant next edge. Dropping `ena` mid-burst: the burst completes with `done`, and no new grant follows.
- **Reset mid-burst:** assert `rst` on beat 2 of a 4-beat write. Next cycle all outputs are 0 and no `done`. After release, with `req=1111`, requester 0 is granted first.

Source files
------------

// File: rtl/uio_bus_arbiter_if.sv
// Bundle of the requester-side handshake and the uio pin bank shared by the arbiter.
// The master side holds the requesters and pins; the slave side is the arbiter.
interface uio_bus_arbiter_if #(
    parameter int NREQ      = 4,
    parameter int MAX_BEATS = 8
);
    localparam int LW = $clog2(MAX_BEATS);

    logic                 ena;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_wr;
    logic [NREQ*LW-1:0]   req_len;
    logic [NREQ*8-1:0]    wdata;
    logic [7:0]           uio_in;

    logic [NREQ-1:0]      gnt;
    logic                 beat;
    logic [NREQ-1:0]      done;
    logic [7:0]           rdata;
    logic                 rvalid;
    logic [7:0]           uio_out;
    logic [7:0]           uio_oe;

    modport master (
        output ena, req, req_wr, req_len, wdata, uio_in,
        input  gnt, beat, done, rdata, rvalid, uio_out, uio_oe
    );

    modport slave (
        input  ena, req, req_wr, req_len, wdata, uio_in,
        output gnt, beat, done, rdata, rvalid, uio_out, uio_oe
    );
endinterface

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the uio pin bank: one burst per grant, with an all-inputs
// turnaround gap before every burst and at least one idle cycle between bursts.
module uio_bus_arbiter #(
    parameter int NREQ       = 4,
    parameter int MAX_BEATS  = 8,
    parameter int TURNAROUND = 1
) (
    input  logic               clk,
    input  logic               rst,
    uio_bus_arbiter_if.slave   bus
);
    localparam int LW = $clog2(MAX_BEATS);
    localparam int OW = $clog2(NREQ);
    localparam int TW = 2;

    typedef enum logic [1:0] {IDLE, TURN, XFER} state_t;

    state_t          state_reg, state_next;
    logic [OW-1:0]   owner_reg, owner_next;
    logic [OW-1:0]   last_owner_reg, last_owner_next;
    logic            wr_reg, wr_next;
    logic [LW-1:0]   beat_cnt_reg, beat_cnt_next;
    logic [TW-1:0]   turn_cnt_reg, turn_cnt_next;
    logic [NREQ-1:0] done_reg, done_next;
    logic [7:0]      rdata_reg, rdata_next;
    logic            rvalid_reg, rvalid_next;

    logic [7:0]      wdata_arr [NREQ];
    logic [LW-1:0]   len_arr   [NREQ];
    logic [NREQ-1:0] owner_onehot;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign wdata_arr[gi]    = bus.wdata[gi*8 +: 8];
            assign len_arr[gi]      = bus.req_len[gi*LW +: LW];
            assign owner_onehot[gi] = (owner_reg == OW'(gi));
        end
    endgenerate

    // Search starts one past the last owner, so a requester that just finished
    // has the lowest priority and a lone requester still wins every time.
    logic          found;
    logic [OW-1:0] pick;
    logic [OW-1:0] idx;
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = OW'((int'(last_owner_reg) + i) % NREQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        wr_next         = wr_reg;
        beat_cnt_next   = beat_cnt_reg;
        turn_cnt_next   = turn_cnt_reg;
        done_next       = '0;
        rdata_next      = rdata_reg;
        rvalid_next     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (bus.ena && found) begin
                    owner_next    = pick;
                    wr_next       = bus.req_wr[pick];
                    beat_cnt_next = len_arr[pick];
                    turn_cnt_next = TW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
                    state_next    = (TURNAROUND == 0) ? XFER : TURN;
                end
            end
            TURN: begin
                if (turn_cnt_reg == '0) state_next = XFER;
                else                    turn_cnt_next = turn_cnt_reg - 1'b1;
            end
            XFER: begin
                if (!wr_reg) begin
                    rdata_next  = bus.uio_in;
                    rvalid_next = 1'b1;
                end
                if (beat_cnt_reg == '0) begin
                    state_next      = IDLE;
                    last_owner_next = owner_reg;
                    done_next       = owner_onehot;
                end else begin
                    beat_cnt_next = beat_cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            owner_reg      <= '0;
            last_owner_reg <= OW'(NREQ - 1);
            wr_reg         <= 1'b0;
            beat_cnt_reg   <= '0;
            turn_cnt_reg   <= '0;
            done_reg       <= '0;
            rdata_reg      <= '0;
            rvalid_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            wr_reg         <= wr_next;
            beat_cnt_reg   <= beat_cnt_next;
            turn_cnt_reg   <= turn_cnt_next;
            done_reg       <= done_next;
            rdata_reg      <= rdata_next;
            rvalid_reg     <= rvalid_next;
        end
    end

    // Pins are driven only in a write beat; every other state leaves them as inputs.
    logic drive;
    assign drive       = (state_reg == XFER) && wr_reg;
    assign bus.gnt     = (state_reg != IDLE) ? owner_onehot : '0;
    assign bus.beat    = (state_reg == XFER);
    assign bus.done    = done_reg;
    assign bus.rdata   = rdata_reg;
    assign bus.rvalid  = rvalid_reg;
    assign bus.uio_oe  = drive ? 8'hFF : 8'h00;
    assign bus.uio_out = drive ? wdata_arr[owner_reg] : 8'h00;
endmodule
